// File: rtl/harmonic_sample_fetcher.sv
// Harmonic sample fetcher: on each codec frame, request one sample from the
// generator, saturate it to 16 bits and hold it for the codec. Missed frames
// and generator timeouts are recorded as underruns.
module harmonic_sample_fetcher #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               codec_frame,
    input  logic               play_enable,
    input  logic               note_done,
    input  logic signed [17:0] harmonic_in,
    input  logic               sample_ready_in,
    output logic               generate_next_sample,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               underrun,
    output logic [7:0]         underrun_count
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDeliver} state_e;

    state_e             state_q, state_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic signed [15:0] sample_q, sample_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         ur_cnt_q, ur_cnt_d;

    logic       silent;
    logic       frame_miss;
    logic       timeout_evt;
    logic [8:0] wait_next;
    logic [1:0] ur_inc;
    logic [8:0] ur_sum;

    // Clamp an 18-bit generator sample into the signed 16-bit codec range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        if (x > 18'sd32767) begin
            return 16'h7fff;
        end else if (x < -18'sd32768) begin
            return 16'h8000;
        end else begin
            return x[15:0];
        end
    endfunction

    assign silent     = !play_enable || note_done;
    assign frame_miss = codec_frame && (state_q != StIdle);
    assign wait_next  = {1'b0, wait_cnt_q} + 9'd1;

    // Next-state, captured sample and underrun bookkeeping.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        sample_d    = sample_q;
        underrun_d  = underrun_q;
        ur_cnt_d    = ur_cnt_q;
        timeout_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (codec_frame) begin
                    if (!silent) begin
                        state_d = StReq;
                    end else begin
                        sample_d = '0;
                        state_d  = StDeliver;
                    end
                end
            end
            StReq: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // A valid sample wins over abort and timeout in the same cycle.
                if (sample_ready_in) begin
                    sample_d = sat16(harmonic_in);
                    state_d  = StDeliver;
                end else if (silent) begin
                    sample_d = '0;
                    state_d  = StDeliver;
                end else if (wait_next >= 9'(TIMEOUT_CYCLES)) begin
                    // Keep the previous sample on timeout.
                    timeout_evt = 1'b1;
                    state_d     = StDeliver;
                end else begin
                    wait_cnt_d = wait_next[7:0];
                end
            end
            StDeliver: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ur_inc = {1'b0, frame_miss} + {1'b0, timeout_evt};
        ur_sum = {1'b0, ur_cnt_q} + {7'd0, ur_inc};
        if (ur_inc != 2'd0) begin
            underrun_d = 1'b1;
        end
        ur_cnt_d = ur_sum[8] ? 8'hff : ur_sum[7:0];
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            sample_q   <= '0;
            underrun_q <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
            ur_cnt_q   <= ur_cnt_d;
        end
    end

    assign generate_next_sample = (state_q == StReq);
    assign sample_valid         = (state_q == StDeliver);
    assign sample_out           = sample_q;
    assign underrun             = underrun_q;
    assign underrun_count       = ur_cnt_q;

endmodule

// File: tb/tb_harmonic_sample_fetcher.sv
// Scoreboard bench for harmonic_sample_fetcher: stimulus pushes the expected
// request pulses and delivered samples (value + cycle); a monitor checks them.
module tb_harmonic_sample_fetcher;

    logic               clk;
    logic               reset;
    logic               codec_frame;
    logic               play_enable;
    logic               note_done;
    logic signed [17:0] harmonic_in;
    logic               sample_ready_in;
    logic               generate_next_sample;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               underrun;
    logic [7:0]         underrun_count;

    typedef struct {
        logic signed [15:0] val;
        int                 cyc;
    } exp_t;

    exp_t sq[$];
    int   gq[$];
    int   cyc;
    int   checks;
    int   fails;

    harmonic_sample_fetcher #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .codec_frame         (codec_frame),
        .play_enable         (play_enable),
        .note_done           (note_done),
        .harmonic_in         (harmonic_in),
        .sample_ready_in     (sample_ready_in),
        .generate_next_sample(generate_next_sample),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .underrun            (underrun),
        .underrun_count      (underrun_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic signed [15:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sq.push_back(e);
    endtask

    // Normal request: ready arrives w cycles after the first WAIT cycle.
    task automatic do_req(input logic signed [17:0] h, input int w,
                          input logic signed [15:0] exp);
        gq.push_back(cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        tick();
        repeat (w) tick();
        sample_ready_in = 1'b1;
        harmonic_in     = h;
        push_sample(exp, cyc + 1);
        tick();
        sample_ready_in = 1'b0;
        tick();
    endtask

    // Monitor: pop and compare whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (generate_next_sample) begin
                if (gq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL gen_unexpected: pulse at cycle %0d, required none", cyc);
                end else begin
                    check("gen_cycle", cyc, gq.pop_front());
                end
            end
            if (sample_valid) begin
                if (sq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL valid_unexpected: sample %0d at cycle %0d, required none",
                             sample_out, cyc);
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    check("sample_value", $signed(sample_out), e.val);
                    check("sample_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        fails           = 0;
        cyc             = 0;
        reset           = 1'b0;
        codec_frame     = 1'b0;
        play_enable     = 1'b1;
        note_done       = 1'b0;
        harmonic_in     = '0;
        sample_ready_in = 1'b0;
        #1;
        check("rst_sample_out", $signed(sample_out), 0);
        check("rst_valid", sample_valid, 0);
        check("rst_gen", generate_next_sample, 0);
        check("rst_underrun", underrun, 0);
        check("rst_count", underrun_count, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Normal path and saturation.
        do_req(18'sd1000, 1, 16'sd1000);
        do_req(18'sd40000, 0, 16'sd32767);
        do_req(-18'sd40000, 0, -16'sd32768);
        do_req(-18'sd5, 1, -16'sd5);
        do_req(18'sd32768, 2, 16'sd32767);
        do_req(-18'sd32768, 0, -16'sd32768);
        do_req(18'sd32767, 0, 16'sd32767);

        // Ready outside WAIT is ignored.
        sample_ready_in = 1'b1;
        harmonic_in     = 18'sd777;
        tick();
        tick();
        sample_ready_in = 1'b0;
        check("ready_ignored", $signed(sample_out), 32767);

        // Silence via note_done, then via play_enable.
        note_done = 1'b1;
        push_sample(16'sd0, cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        note_done   = 1'b0;
        tick();
        do_req(18'sd200, 0, 16'sd200);
        play_enable = 1'b0;
        push_sample(16'sd0, cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        play_enable = 1'b1;
        tick();

        // Abort mid-WAIT delivers zero without underrun.
        gq.push_back(cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        tick();
        play_enable = 1'b0;
        push_sample(16'sd0, cyc + 1);
        tick();
        play_enable = 1'b1;
        tick();
        check("abort_underrun", underrun, 0);
        check("abort_count", underrun_count, 0);

        // Timeout holds the previous sample (200).
        do_req(18'sd200, 0, 16'sd200);
        gq.push_back(cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        push_sample(16'sd200, cyc + 5);
        repeat (4) tick();
        check("pre_timeout_underrun", underrun, 0);
        tick();
        check("timeout_underrun", underrun, 1);
        check("timeout_count", underrun_count, 1);
        tick();

        // Frames during WAIT are dropped; the live request still completes.
        for (int i = 0; i < 300; i++) begin
            gq.push_back(cyc + 1);
            codec_frame = 1'b1;
            tick();
            codec_frame = 1'b0;
            tick();
            codec_frame = 1'b1;
            tick();
            codec_frame     = 1'b0;
            sample_ready_in = 1'b1;
            harmonic_in     = 18'(i);
            push_sample(16'(i), cyc + 1);
            tick();
            sample_ready_in = 1'b0;
            tick();
            if (i == 9) check("overlap_count_mid", underrun_count, 11);
        end
        check("overlap_underrun", underrun, 1);
        check("overlap_count_sat", underrun_count, 255);

        // Reset two cycles after the request abandons it.
        gq.push_back(cyc + 1);
        codec_frame = 1'b1;
        tick();
        codec_frame = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst_sample_out", $signed(sample_out), 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_gen", generate_next_sample, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_count", underrun_count, 0);
        tick();
        reset = 1'b1;
        sample_ready_in = 1'b1;
        harmonic_in     = 18'sd999;
        repeat (3) tick();
        sample_ready_in = 1'b0;
        check("postrst_sample_out", $signed(sample_out), 0);
        do_req(18'sd1234, 0, 16'sd1234);

        repeat (3) tick();
        check("sample_queue_empty", sq.size(), 0);
        check("gen_queue_empty", gq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/harmonic_sample_fetcher.md
HARMONIC_SAMPLE_FETCHER -- requirements
Module: harmonic_sample_fetcher

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles spent in WAIT before declaring underrun (range 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 codec_frame  input  1  one-cycle strobe; codec requests one new output sample.
REQ-005 play_enable  input  1  level; 0 means emit silence.
REQ-006 note_done  input  1  level; 1 means emit silence.
REQ-007 harmonic_in  input  18  signed weighted harmonic sample from the generator.
REQ-008 sample_ready_in  input  1  generator indicates harmonic_in is valid.
REQ-009 generate_next_sample  output  1  one-cycle request pulse to the generator.
REQ-010 sample_out  output  16  signed sample held for the codec.
REQ-011 sample_valid  output  1  one-cycle pulse; sample_out updated this cycle.
REQ-012 underrun  output  1  sticky flag; set on timeout or missed frame.
REQ-013 underrun_count  output  8  saturating count of underrun events.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, DELIVER.
REQ-015 IDLE: on codec_frame with play_enable=1 and note_done=0 -> REQ; on codec_frame otherwise -> DELIVER with zero sample; else stay.
REQ-016 REQ: generate_next_sample SHALL be 1 for exactly this one cycle; wait counter cleared; -> WAIT.
REQ-017 generate_next_sample SHALL be 0 in every state other than REQ.
REQ-018 WAIT: on sample_ready_in=1, capture saturated harmonic_in -> DELIVER; counter increments each WAIT cycle without sample_ready_in.
REQ-019 WAIT timeout: when counter reaches TIMEOUT_CYCLES without sample_ready_in, hold previous sample_out value, set underrun, increment underrun_count -> DELIVER.
REQ-020 WAIT: if play_enable=0 or note_done=1 in a cycle without sample_ready_in, the SHALL-deliver value is zero; -> DELIVER, no underrun.
REQ-021 sample_ready_in and captured value take priority over abort and timeout in the same cycle.
REQ-022 DELIVER: sample_out updated, sample_valid=1 for exactly this cycle -> IDLE.
REQ-023 Saturation: harmonic_in > 32767 -> 32767; harmonic_in < -32768 -> -32768; else low 16 bits sign-preserved.
REQ-024 sample_ready_in outside WAIT SHALL be ignored (no capture, no state change).
REQ-025 codec_frame outside IDLE SHALL be dropped, set underrun and increment underrun_count; no second request queued.
REQ-026 underrun_count SHALL saturate at 255, not wrap.
REQ-027 Latency: codec_frame at cycle N -> generate_next_sample at N+1; sample_ready_in at cycle M -> sample_valid and new sample_out at M+1.
REQ-028 Silence path latency: codec_frame at N (silent) -> sample_valid with sample_out=0 at N+1.
REQ-029 sample_out SHALL hold its value between sample_valid pulses.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE, generate_next_sample=0, sample_valid=0, sample_out=0, underrun=0, underrun_count=0, wait counter=0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the request; no sample_valid issued for it after release.
REQ-032 First codec_frame after reset release SHALL be handled normally from IDLE.

Verification
REQ-033 Normal: play_enable=1, codec_frame at N, sample_ready_in=1 with harmonic_in=1000 at N+3 -> generate pulse at N+1, sample_valid at N+4, sample_out=1000.
REQ-034 Saturation: harmonic_in=+40000 then -40000 -> sample_out=32767 then -32768; harmonic_in=-5 -> -5.
REQ-035 Timeout: TIMEOUT_CYCLES=4, prior sample 200, no sample_ready_in -> sample_valid 5 cycles after request, sample_out=200, underrun=1, count=1.
REQ-036 Silence: note_done=1, codec_frame -> no generate pulse, sample_valid next cycle, sample_out=0.
REQ-037 Overlap/saturation: codec_frame during WAIT, 300 times -> request unaffected, underrun=1, underrun_count=255.
REQ-038 Reset mid-WAIT: reset=0 two cycles after request, then sample_ready_in=1 after release -> all outputs 0, no sample_valid.
